// File: rtl/pcpu_pkg.sv
// pcpu_pkg: pcpu opcodes, NOP word, 32-bit instruction layout (opcode in [31:26]) and fetch-unit state/queue-entry types
package pcpu_pkg;
  localparam int XLEN = 32;
  typedef logic [5:0] opcode_t;
  localparam opcode_t OP_NOP = 6'h00;
  localparam opcode_t OP_LOAD = 6'h01;
  localparam opcode_t OP_STORE = 6'h02;
  localparam opcode_t OP_BEQ = 6'h04;
  localparam opcode_t OP_BNE = 6'h05;
  localparam opcode_t OP_JMP = 6'h08;
  localparam opcode_t OP_HALT = 6'h3f;
  localparam logic [XLEN-1:0] NOP_WORD = {OP_NOP, 26'b0};
  typedef enum logic [1:0] {IF_IDLE, IF_FETCH, IF_HALTED} if_state_t;
  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
  } if_entry_t;
  function automatic opcode_t opcode_of(input logic [XLEN-1:0] w);
    return w[31:26];
  endfunction
endpackage

// File: rtl/if_fifo.sv
// if_fifo: DEPTH-entry synchronous queue of {instruction, pc}; ports clock/reset, flush (beats push), push/din, pop/dout, count/full/empty
module if_fifo
  import pcpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  if_entry_t              din,
  input  logic                   pop,
  output if_entry_t              dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  if_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr + AW'(1);
      end
      if (do_pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: pcpu fetch front end (fetch PC, imem req/gnt/rvalid, prefetch queue, ins valid/ready to ID, redirect, halted); IF_BYPASS_EN adds empty-queue rdata bypass
module if_prefetch_unit
  import pcpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_out,
  output logic [31:0] ins_pc,
  output logic        halted
);
  localparam int CW = $clog2(DEPTH) + 1;
  if_state_t state, state_n;
  logic [31:0] pc, rsp_pc;
  logic [CW-1:0] outstanding, out_n, drop, count;
  logic full, empty, issue, rsp_live, accept, byp, push, pop, halt_enq;
  if_entry_t head, entry;
  assign imem_req = state == IF_FETCH && count + outstanding < CW'(DEPTH);
  assign imem_addr = redirect ? redirect_pc : pc;
  assign issue = imem_req && imem_gnt;
  assign rsp_live = imem_rvalid && outstanding != '0;
  assign accept = rsp_live && drop == '0 && !redirect;
`ifdef IF_BYPASS_EN
  assign byp = accept && empty && ins_ready;
`else
  assign byp = 1'b0;
`endif
  assign push = accept && !byp && !full;
  assign pop = ins_ready && !empty;
  assign halt_enq = accept && opcode_of(imem_rdata) == OP_HALT;
  assign out_n = outstanding + CW'(issue) - CW'(rsp_live);
  assign entry = '{ins: imem_rdata, pc: rsp_pc};
  assign ins_valid = !empty || byp;
  assign ins_out = !empty ? head.ins : byp ? imem_rdata : NOP_WORD;
  assign ins_pc = !empty ? head.pc : byp ? rsp_pc : '0;
  always_comb state_n = state == IF_HALTED ? (redirect ? IF_FETCH : IF_HALTED) :
                        state == IF_IDLE ? (enable ? IF_FETCH : IF_IDLE) :
                        !enable ? IF_IDLE : halt_enq ? IF_HALTED : IF_FETCH;
  always_ff @(posedge clock) begin
    state <= reset ? IF_IDLE : state_n;
    halted <= !reset && state_n == IF_HALTED;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
    end else begin
      outstanding <= out_n;
      drop <= redirect ? out_n : drop - CW'(rsp_live && drop != '0);
      pc <= redirect ? redirect_pc : issue ? pc + PC_STEP : pc;
      rsp_pc <= redirect ? redirect_pc : accept ? rsp_pc + PC_STEP : rsp_pc;
    end
  end
  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(redirect),
    .push(push),
    .din(entry),
    .pop(pop),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: scoreboard bench for if_prefetch_unit with a latency-programmable instruction memory model
module tb_if_prefetch_unit;
  import pcpu_pkg::*;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  logic clock = 0, reset = 1, enable = 0, redirect = 0, imem_gnt = 0, imem_rvalid = 0, ins_ready = 0, gnt_en = 1;
  logic [31:0] redirect_pc = 0, imem_rdata = 0, halt_at = '1, max_addr = 0, mon_e;
  logic [31:0] imem_addr, ins_out, ins_pc;
  logic imem_req, ins_valid, halted;
  int checks = 0, errors = 0, cyc = 0, lat = 1, gnt_count = 0, del_count = 0, del_cyc = 0, first_del_cyc = 0;
  pend_t pend[$];
  logic [31:0] exp_q[$];

  if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'd1)) dut (
    .clock(clock), .reset(reset), .enable(enable), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_out(ins_out),
    .ins_pc(ins_pc), .halted(halted)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a == halt_at ? {OP_HALT, 26'b0} : {OP_LOAD, a[25:0]};
  endfunction

  always @(negedge clock) begin
    pend_t p;
    #1;
    imem_rvalid = 0;
    if (reset) begin
      pend.delete();
      imem_gnt = 0;
    end else begin
      imem_gnt = gnt_en;
      if (imem_req && imem_gnt) begin
        p.addr = imem_addr;
        p.due = cyc + lat;
        pend.push_back(p);
        gnt_count++;
        if (imem_addr > max_addr) max_addr = imem_addr;
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        imem_rvalid = 1;
        imem_rdata = word(p.addr);
      end
    end
  end

  always @(negedge clock) begin
    #2;
    if (!reset && ins_valid && ins_ready) begin
      checks++;
      if (del_count == 0) first_del_cyc = cyc;
      del_count++;
      del_cyc = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL deliver: unexpected ins_pc=%h ins_out=%h, none required", ins_pc, ins_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (ins_pc !== mon_e || ins_out !== word(mon_e)) begin
          errors++;
          $display("FAIL deliver: got pc=%h ins=%h, required pc=%h ins=%h", ins_pc, ins_out, mon_e, word(mon_e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1; enable = 0; redirect = 0; ins_ready = 0; gnt_en = 1; lat = 1; halt_at = '1;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 0; max_addr = 0; gnt_count = 0; del_count = 0;
  endtask

  task automatic wait_done(input int bound, input string name);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) begin
      @(negedge clock);
      #3;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s: %0d words undelivered after %0d cycles, required 0", name, exp_q.size(), bound);
    end
    @(negedge clock);
    ins_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ins_valid); end
    checks++; if (ins_out !== NOP_WORD) begin errors++; $display("FAIL reset_ins: got %h want %h", ins_out, NOP_WORD); end
    checks++; if (ins_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", ins_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
  endtask

  task automatic test_back_to_back();
    int e0;
    do_reset();
    for (int k = 0; k < 12; k++) exp_q.push_back(32'(k));
    ins_ready = 1;
    enable = 1;
    e0 = cyc;
    wait_done(60, "stream");
    checks++; if (first_del_cyc != e0 + 3) begin errors++; $display("FAIL fill_latency: first at %0d want %0d", first_del_cyc - e0, 3); end
    checks++; if (del_cyc - first_del_cyc != 11) begin errors++; $display("FAIL back_to_back: span %0d want 11", del_cyc - first_del_cyc); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 10; k++) exp_q.push_back(32'(k));
    enable = 1;
    repeat (7) @(negedge clock);
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", imem_req); end
    checks++; if (gnt_count != 4) begin errors++; $display("FAIL stall_grants: got %0d want 4", gnt_count); end
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", ins_valid); end
    @(negedge clock);
    ins_ready = 1;
    wait_done(60, "stall_release");
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 4;
    gnt_en = 0;
    ins_ready = 1;
    enable = 1;
    repeat (2) @(negedge clock);
    #3;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL hold_addr: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    gnt_en = 1;
    repeat (2) @(negedge clock);
    #3;
    gnt_en = 0;
    @(negedge clock);
    redirect = 1;
    redirect_pc = 32'h40;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h40 + 32'(k));
    #3;
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redirect_addr: got %h want 40", imem_addr); end
    @(negedge clock);
    redirect = 0;
    gnt_en = 1;
    #3;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL redirect_valid: got %b want 0", ins_valid); end
    wait_done(80, "redirect");
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    enable = 1;
    repeat (3) @(negedge clock);
    redirect = 1;
    redirect_pc = 32'h80;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h80 + 32'(k));
    #3;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin errors++; $display("FAIL coinc_req: got req=%b addr=%h want 1/80", imem_req, imem_addr); end
    @(negedge clock);
    redirect = 0;
    ins_ready = 1;
    #3;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL coinc_flush: got valid=%b want 0", ins_valid); end
    wait_done(60, "redirect_rvalid_gnt");
  endtask

  task automatic test_halt();
    do_reset();
    halt_at = 32'd5;
    for (int k = 0; k < 7; k++) exp_q.push_back(32'(k));
    ins_ready = 1;
    enable = 1;
    for (int i = 0; i < 40 && halted !== 1'b1; i++) @(negedge clock);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_wait: got halted=%b want 1", halted); end
    repeat (3) @(negedge clock);
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req: got %b want 0", imem_req); end
    checks++; if (max_addr !== 32'd6) begin errors++; $display("FAIL halt_cap: max addr %0d want 6", max_addr); end
    wait_done(40, "halt_drain");
    halt_at = '1;
    redirect = 1;
    redirect_pc = 32'h0;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
    ins_ready = 1;
    @(negedge clock);
    redirect = 0;
    #3;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_resume: got halted=%b want 0", halted); end
    wait_done(40, "halt_resume");
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1;
    repeat (5) @(negedge clock);
    #3;
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL mid_fill: got valid=%b want 1", ins_valid); end
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    #3;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", ins_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h want 0", imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_halted: got %b want 0", halted); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b want 0", imem_req); end
    @(negedge clock);
    reset = 0;
    enable = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect();
    test_redirect_coincident();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
